// File: rtl/ram_addr_pkg.sv
// Shared types for the RAM write-address sequencer.
package ram_addr_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/strobe_rise_det.sv
// Rising-edge detector for an active-low strobe: one step per completed low phase.
module strobe_rise_det (
  input  logic clk_2,
  input  logic reset_n,
  input  logic strb_n,
  output logic step
);

  logic strb_n_q;

  // Idle-high history, so a strobe that is high when reset releases is not seen as an edge.
  always_ff @(posedge clk_2) begin
    if (!reset_n) strb_n_q <= 1'b1;
    else          strb_n_q <= strb_n;
  end

  assign step = !strb_n_q && strb_n;

endmodule

// File: rtl/ram_addr_seq.sv
// Parametrised RAM write-address sequencer: steps once per ram_wr_n strobe,
// up or down from start_addr to end_addr, then wraps or stops.
module ram_addr_seq
  import ram_addr_pkg::*;
#(
  parameter int                ADDR_W     = 11,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '1
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              dir,
  input  logic              wrap_en,
  input  logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              ovr,
  output logic [ADDR_W:0]   wr_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              dir;
    logic              wrap_en;
  } seq_cfg_t;

  seq_cfg_t          cfg;
  seq_state_t        state;
  logic              step;
  logic              at_end;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  strobe_rise_det u_rise (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .strb_n  (ram_wr_n),
    .step    (step)
  );

  always_comb begin
    at_end   = (ram_addr == cfg.end_addr);
    addr_nxt = (cfg.dir == DIR_UP) ? ram_addr + 1'b1 : ram_addr - 1'b1;
    cnt_nxt  = (&wr_count) ? wr_count : wr_count + 1'b1;
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      ram_addr <= RESET_ADDR;
      cfg      <= '0;
      state    <= SEQ_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      ovr      <= 1'b0;
      wr_count <= '0;
    end else begin
      wrap <= 1'b0;
      ovr  <= 1'b0;
      // start wins over a coincident step; that step is simply dropped
      if (start) begin
        ram_addr <= start_addr;
        cfg      <= '{start_addr: start_addr, end_addr: end_addr,
                      dir: dir, wrap_en: wrap_en};
        wr_count <= '0;
        done     <= 1'b0;
        state    <= SEQ_RUN;
        busy     <= 1'b1;
      end else if (step) begin
        case (state)
          SEQ_RUN: begin
            wr_count <= cnt_nxt;
            if (!at_end) begin
              ram_addr <= addr_nxt;
            end else if (cfg.wrap_en) begin
              ram_addr <= cfg.start_addr;
              wrap     <= 1'b1;
            end else begin
              state <= SEQ_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ovr <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_addr_seq.sv
// Directed self-checking bench for ram_addr_seq (ADDR_W=11).
module tb_ram_addr_seq;

  localparam int ADDR_W = 11;

  logic              clk_2 = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              dir;
  logic              wrap_en;
  logic              ram_wr_n;
  logic [ADDR_W-1:0] ram_addr;
  logic              busy;
  logic              done;
  logic              wrap;
  logic              ovr;
  logic [ADDR_W:0]   wr_count;

  int checks   = 0;
  int failures = 0;

  ram_addr_seq #(.ADDR_W(ADDR_W)) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .dir        (dir),
    .wrap_en    (wrap_en),
    .ram_wr_n   (ram_wr_n),
    .ram_addr   (ram_addr),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap),
    .ovr        (ovr),
    .wr_count   (wr_count)
  );

  always #5 clk_2 = ~clk_2;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 1-cycle low strobe; on return the step edge has just happened.
  task automatic strobe();
    ram_wr_n = 1'b0;
    tick();
    ram_wr_n = 1'b1;
    tick();
  endtask

  task automatic do_start(input int sa, input int ea, input logic d, input logic w);
    start      = 1'b1;
    start_addr = sa[ADDR_W-1:0];
    end_addr   = ea[ADDR_W-1:0];
    dir        = d;
    wrap_en    = w;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    dir = 1'b0; wrap_en = 1'b0; ram_wr_n = 1'b1;
    tick(); tick();
    chk("rst_addr", 32'(ram_addr), 32'h7FF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt",  32'(wr_count), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_ovr",  32'(ovr), 0);
    reset_n = 1'b1;
    tick();

    // down count 10 -> 7, stop
    do_start(10, 7, 1'b0, 1'b0);
    chk("dn_start_addr", 32'(ram_addr), 10);
    chk("dn_start_busy", 32'(busy), 1);
    strobe(); chk("dn_s1", 32'(ram_addr), 9);
    strobe(); chk("dn_s2", 32'(ram_addr), 8);
    strobe(); chk("dn_s3", 32'(ram_addr), 7);
    chk("dn_s3_busy", 32'(busy), 1);
    strobe(); chk("dn_s4", 32'(ram_addr), 7);
    chk("dn_done", 32'(done), 1);
    chk("dn_busy", 32'(busy), 0);
    chk("dn_cnt",  32'(wr_count), 4);
    strobe();
    chk("dn_ovr",      32'(ovr), 1);
    chk("dn_ovr_addr", 32'(ram_addr), 7);
    chk("dn_ovr_cnt",  32'(wr_count), 4);
    tick();
    chk("dn_ovr_pulse", 32'(ovr), 0);
    chk("dn_done_hold", 32'(done), 1);

    // up count across all-ones with wrap
    do_start(2046, 1, 1'b1, 1'b1);
    chk("up_done_clr", 32'(done), 0);
    strobe(); chk("up_s1", 32'(ram_addr), 2047);
    strobe(); chk("up_s2", 32'(ram_addr), 0);
    strobe(); chk("up_s3", 32'(ram_addr), 1);
    chk("up_s3_wrap", 32'(wrap), 0);
    strobe(); chk("up_s4", 32'(ram_addr), 2046);
    chk("up_s4_wrap", 32'(wrap), 1);
    strobe(); chk("up_s5", 32'(ram_addr), 2047);
    chk("up_s5_wrap", 32'(wrap), 0);
    chk("up_cnt", 32'(wr_count), 5);

    // long strobe: one step, address stable while low
    ram_wr_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("long_low_addr", 32'(ram_addr), 2047);
    end
    ram_wr_n = 1'b1;
    tick();
    chk("long_step", 32'(ram_addr), 0);
    chk("long_cnt",  32'(wr_count), 6);
    tick();
    chk("long_once", 32'(ram_addr), 0);

    // start coincident with strobe rising edge
    ram_wr_n = 1'b0;
    tick();
    ram_wr_n = 1'b1;
    do_start(100, 110, 1'b1, 1'b0);
    chk("coinc_addr", 32'(ram_addr), 100);
    chk("coinc_cnt",  32'(wr_count), 0);
    chk("coinc_busy", 32'(busy), 1);
    tick();
    chk("coinc_hold", 32'(ram_addr), 100);

    // start==end completes in one strobe
    do_start(50, 50, 1'b1, 1'b0);
    strobe();
    chk("eq_addr", 32'(ram_addr), 50);
    chk("eq_done", 32'(done), 1);
    chk("eq_cnt",  32'(wr_count), 1);

    // down across zero; config changes while running are ignored
    do_start(1, 2045, 1'b0, 1'b0);
    dir = 1'b1; end_addr = 11'd0; wrap_en = 1'b1;
    strobe(); chk("dz_s1", 32'(ram_addr), 0);
    strobe(); chk("dz_s2", 32'(ram_addr), 2047);
    strobe(); chk("dz_s3", 32'(ram_addr), 2046);
    strobe(); chk("dz_s4", 32'(ram_addr), 2045);
    strobe(); chk("dz_done", 32'(done), 1);
    chk("dz_wrap", 32'(wrap), 0);

    // wr_count saturates at all-ones
    do_start(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4100; i++) strobe();
    chk("sat_cnt",  32'(wr_count), 32'hFFF);
    chk("sat_addr", 32'(ram_addr), 0);

    // reset mid-RUN aborts the sequence
    do_start(3, 20, 1'b1, 1'b0);
    strobe(); strobe();
    chk("mid_addr", 32'(ram_addr), 5);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_addr", 32'(ram_addr), 32'h7FF);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt",  32'(wr_count), 0);
    reset_n = 1'b1;
    tick();
    strobe();
    chk("mid_ovr",      32'(ovr), 1);
    chk("mid_ovr_addr", 32'(ram_addr), 32'h7FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
